// File: rtl/his_builder_pkg.sv
// Shared defaults, FSM state encoding and width helpers for the histogram peak builder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package his_builder_pkg;

    localparam int NP_DEF            = 10;
    localparam int PIXEL_NUM_DEF     = 3;
    localparam int ACQ_NUM_DEF       = 16;
    localparam int BIN_BITS_DEF      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } hisState_t;

    // Index width that never collapses to zero bits when the range is a single entry.
    function automatic int safeClog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/his_peak_tracker.sv
// Per-pixel peak tracker: keeps the highest histogram count seen and the lower edge of its bin.
// Latency: 1 cycle, an update strobed at edge k is visible in peakResult after edge k.
// Backpressure: none, every strobed update is absorbed in the same cycle.
//
// Ports: clk/res (sync, active-high) | upd strobe, newCnt (post-increment bin count),
//        bin (bin index of the sample) | peakResult (bin lower edge of the current peak).
module his_peak_tracker #(
    parameter int NP       = 10,
    parameter int BIN_BITS = 4,
    parameter int CW       = 5
) (
    input  logic                clk,
    input  logic                res,
    input  logic                upd,
    input  logic [CW-1:0]       newCnt,
    input  logic [BIN_BITS-1:0] bin,
    output logic [NP-1:0]       peakResult
);

    logic [CW-1:0] peakCnt;

    // Strictly-greater compare: on a tie the bin that reached the count first stays the peak.
    always_ff @(posedge clk) begin
        if (res) begin
            peakCnt    <= '0;
            peakResult <= '0;
        end else if (upd && (newCnt > peakCnt)) begin
            peakCnt    <= newCnt;
            peakResult <= NP'(bin) << (NP - BIN_BITS);
        end
    end

endmodule

// File: rtl/his_builder_fsm.sv
// Builds per-pixel TDC histograms over a frame of acquisitions and reports each pixel's peak bin.
// Latency: 1 cycle from an accepted sample to its effect on peakResult; done rises one cycle after the last sample.
// Backpressure: none; wrEn is ignored once the frame is complete until res.
//
// Ports: clk, res (sync, active-high) | wrEn, data (timestamp for the current pixel, 0 = no photon)
//        | peakResult[pixel] (peak bin lower edge), done (frame complete).
module his_builder_fsm
    import his_builder_pkg::*;
#(
    parameter int NP                = NP_DEF,
    parameter int PIXEL_NUM_PER_RAM = PIXEL_NUM_DEF,
    parameter int ACQ_NUM           = ACQ_NUM_DEF,
    parameter int BIN_BITS          = BIN_BITS_DEF
) (
    input  logic          clk,
    input  logic          res,
    input  logic          wrEn,
    input  logic [NP-1:0] data,
    output logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM-1:0],
    output logic          done
);

    localparam int CW    = $clog2(ACQ_NUM + 1);
    localparam int PW    = safeClog2(PIXEL_NUM_PER_RAM);
    localparam int AW    = safeClog2(ACQ_NUM);
    localparam int NBINS = 1 << BIN_BITS;

    hisState_t           state;
    hisState_t           stateNext;
    logic                accept;
    logic                sampleHit;
    logic                lastSample;
    logic [PW-1:0]       pixPtr;
    logic [AW-1:0]       acqCnt;
    logic [BIN_BITS-1:0] bin;
    logic [CW-1:0]       curCnt;
    logic [CW-1:0]       newCnt;
    logic [CW-1:0]       hist [PIXEL_NUM_PER_RAM][NBINS];

    assign bin        = data[NP-1 -: BIN_BITS];
    assign lastSample = (pixPtr == PW'(PIXEL_NUM_PER_RAM - 1)) && (acqCnt == AW'(ACQ_NUM - 1));
    assign sampleHit  = accept && (data != '0);

    // Read-modify-write happens entirely within one cycle on registers, so back-to-back
    // samples to the same pixel (single-pixel configuration) see the freshly written count.
    assign curCnt = hist[pixPtr][bin];
    assign newCnt = (&curCnt) ? curCnt : curCnt + CW'(1);

    // State register
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; the final sample may also be the very first when the frame is one sample long.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (wrEn) begin
                    stateNext = lastSample ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (wrEn && lastSample) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = DONE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        accept = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE:    accept = wrEn;
            ACCUM:   accept = wrEn;
            DONE:    done   = 1'b1;
            default: accept = 1'b0;
        endcase
    end

    // Pointers and histogram storage
    always_ff @(posedge clk) begin
        if (res) begin
            pixPtr <= '0;
            acqCnt <= '0;
            for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                for (int b = 0; b < NBINS; b++) begin
                    hist[p][b] <= '0;
                end
            end
        end else if (accept) begin
            if (pixPtr == PW'(PIXEL_NUM_PER_RAM - 1)) begin
                pixPtr <= '0;
                acqCnt <= acqCnt + AW'(1);
            end else begin
                pixPtr <= pixPtr + PW'(1);
            end
            if (sampleHit) begin
                hist[pixPtr][bin] <= newCnt;
            end
        end
    end

    for (genvar p = 0; p < PIXEL_NUM_PER_RAM; p++) begin : gPeak
        his_peak_tracker #(
            .NP       (NP),
            .BIN_BITS (BIN_BITS),
            .CW       (CW)
        ) uPeak (
            .clk        (clk),
            .res        (res),
            .upd        (sampleHit && (pixPtr == PW'(p))),
            .newCnt     (newCnt),
            .bin        (bin),
            .peakResult (peakResult[p])
        );
    end

endmodule

// File: tb/tb_his_builder_fsm.sv
// Self-checking bench for his_builder_fsm with a reference histogram model and scoreboard queue.
// Latency: expected state is pushed when a sample is driven and popped one edge later.
// Backpressure: none, the bench drives one stimulus per cycle.
module tb_his_builder_fsm;

    localparam int NP  = 10;
    localparam int PIX = 3;
    localparam int ACQ = 16;

    logic          clk;
    logic          res;
    logic          wrEn;
    logic [NP-1:0] data;
    logic [NP-1:0] peakResult [PIX-1:0];
    logic          done;

    his_builder_fsm #(
        .NP                (NP),
        .PIXEL_NUM_PER_RAM (PIX),
        .ACQ_NUM           (ACQ),
        .BIN_BITS          (4)
    ) dut (
        .clk        (clk),
        .res        (res),
        .wrEn       (wrEn),
        .data       (data),
        .peakResult (peakResult),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [PIX-1:0][NP-1:0] pk;
        logic                   dn;
    } exp_t;

    exp_t sbQ[$];

    int nChecks = 0;
    int nErrors = 0;

    // Reference model state
    int        mCnt     [PIX][16];
    int        mPeakCnt [PIX];
    logic [9:0] mPeak   [PIX];
    int        mPix;
    int        mAcq;
    logic      mDone;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int p = 0; p < PIX; p++) begin
            for (int b = 0; b < 16; b++) mCnt[p][b] = 0;
            mPeakCnt[p] = 0;
            mPeak[p]    = '0;
        end
        mPix  = 0;
        mAcq  = 0;
        mDone = 1'b0;
    endtask

    task automatic modelAccept(input logic [9:0] d);
        int b;
        if (d != 0) begin
            b = int'(d) / 64;
            if (mCnt[mPix][b] < 31) mCnt[mPix][b]++;
            if (mCnt[mPix][b] > mPeakCnt[mPix]) begin
                mPeakCnt[mPix] = mCnt[mPix][b];
                mPeak[mPix]    = 10'(b * 64);
            end
        end
        mPix++;
        if (mPix == PIX) begin
            mPix = 0;
            mAcq++;
            if (mAcq == ACQ) mDone = 1'b1;
        end
    endtask

    // Drive one cycle, record the expected post-edge state, then compare against the DUT.
    task automatic step(input logic r, input logic en, input logic [9:0] d);
        exp_t e;
        res  = r;
        wrEn = en;
        data = d;
        if (r) modelReset();
        else if (en && !mDone) modelAccept(d);
        for (int p = 0; p < PIX; p++) e.pk[p] = mPeak[p];
        e.dn = mDone;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        e = sbQ.pop_front();
        for (int p = 0; p < PIX; p++)
            checkVal($sformatf("peak%0d", p), 32'(peakResult[p]), 32'(e.pk[p]));
        checkVal("done", 32'(done), 32'(e.dn));
        res  = 1'b0;
        wrEn = 1'b0;
    endtask

    task automatic sendWithGaps(input logic [9:0] d);
        if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 10'($urandom_range(0, 1023)));
        step(1'b0, 1'b1, d);
    endtask

    initial begin
        logic [9:0] d;
        res  = 1'b1;
        wrEn = 1'b0;
        data = '0;
        modelReset();

        // Reset state
        step(1'b1, 1'b0, 10'd0);
        checkVal("rst_done", 32'(done), 32'd0);

        // Acquisition 0
        step(1'b0, 1'b1, 10'd108);
        checkVal("a0_pk0", 32'(peakResult[0]), 32'd64);
        checkVal("a0_pk1", 32'(peakResult[1]), 32'd0);
        checkVal("a0_pk2", 32'(peakResult[2]), 32'd0);
        step(1'b0, 1'b0, 10'd777);
        step(1'b0, 1'b1, 10'd511);
        checkVal("a0_pk1_first", 32'(peakResult[1]), 32'd448);
        step(1'b0, 1'b1, 10'd200);
        checkVal("a0_pk2_first", 32'(peakResult[2]), 32'd192);

        // Acquisition 1: tie on pixel 1 keeps the earlier peak
        step(1'b0, 1'b1, 10'd0);
        step(1'b0, 1'b1, 10'd1022);
        checkVal("a1_pk1_tie", 32'(peakResult[1]), 32'd448);
        step(1'b0, 1'b1, 10'd250);
        checkVal("a1_pk2", 32'(peakResult[2]), 32'd192);

        // Acquisition 2: pixel 1 bin 15 overtakes, pixel 2 lower count does not
        step(1'b0, 1'b1, 10'd0);
        step(1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b1, 10'd1022);
        checkVal("a2_pk1_win", 32'(peakResult[1]), 32'd960);
        step(1'b0, 1'b1, 10'd90);
        checkVal("a2_pk2_hold", 32'(peakResult[2]), 32'd192);
        checkVal("a2_pk0", 32'(peakResult[0]), 32'd64);

        // Remaining 39 samples with random gaps; done must rise right after the 48th
        for (int i = 9; i < PIX * ACQ; i++) begin
            d = ($urandom_range(0, 4) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            sendWithGaps(d);
            if (i == PIX * ACQ - 2) checkVal("done_before_last", 32'(done), 32'd0);
            if (i == PIX * ACQ - 1) checkVal("done_after_last", 32'(done), 32'd1);
        end

        // Writes after completion are ignored
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 10'd1023);
        checkVal("done_hold", 32'(done), 32'd1);

        // Mid-frame reset, with wrEn asserted alongside res
        step(1'b1, 1'b0, 10'd0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 10'($urandom_range(1, 1023)));
        step(1'b1, 1'b1, 10'd1023);
        checkVal("mid_rst_pk0", 32'(peakResult[0]), 32'd0);
        checkVal("mid_rst_pk1", 32'(peakResult[1]), 32'd0);
        checkVal("mid_rst_pk2", 32'(peakResult[2]), 32'd0);
        checkVal("mid_rst_done", 32'(done), 32'd0);
        step(1'b0, 1'b1, 10'd1023);
        checkVal("post_rst_pix0", 32'(peakResult[0]), 32'd960);
        checkVal("post_rst_pix1", 32'(peakResult[1]), 32'd0);
        step(1'b0, 1'b1, 10'd300);
        checkVal("post_rst_pix1b", 32'(peakResult[1]), 32'd256);

        // Full frame of empty samples
        step(1'b1, 1'b0, 10'd0);
        for (int i = 0; i < PIX * ACQ; i++) begin
            step(1'b0, 1'b1, 10'd0);
            if (i == PIX * ACQ - 2) checkVal("zero_done_early", 32'(done), 32'd0);
        end
        checkVal("zero_done", 32'(done), 32'd1);
        for (int p = 0; p < PIX; p++)
            checkVal($sformatf("zero_pk%0d", p), 32'(peakResult[p]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
